ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline. Sits between decode and memory access.
- Registers the decode-to-execute bus and performs ALU operations.
- Owns the HI/LO registers. Runs multi-cycle divide (and optionally multiply) with a stall request.
- Issues the data SRAM request, forwards its result back to decode, and produces the execute-to-memory bus.

---
 rtl/ex_stage_if.sv | 30 +++
 rtl/ex_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Decode/execute/memory bundle of ex_stage: stall vector and decode bus in;
// EX->MEM bus, forwarding, data SRAM request and stall request out.
interface ex_stage_if #(
    parameter int ID_TO_EX_WD  = 167,
    parameter int EX_TO_MEM_WD = 76
);
    logic [5:0]              stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic                    ex_rf_we;
    logic [4:0]              ex_rf_waddr;
    logic [31:0]             ex_ex_result;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq_for_ex;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_rf_we, ex_rf_waddr, ex_ex_result,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_rf_we, ex_rf_waddr, ex_ex_result,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, ALU, HI/LO, data SRAM request; ITER_MUL_EN selects iterative mult.
// Latency: outputs combinational from the input register; a divide holds execute DIV_CYCLES+2 cycles.
// Backpressure: stallreq_for_ex holds upstream stages while the multi-cycle unit is busy.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 167,
    parameter int EX_TO_MEM_WD = 76,
    parameter int DIV_CYCLES   = 32
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} md_state_t;

    logic [ID_TO_EX_WD-1:0] r_id;
    md_state_t              r_state;
    logic                   r_done;
    logic [CW-1:0]          r_cnt;
    logic [31:0]            r_hi, r_lo, r_dvsr, r_quo, r_rem;

    logic        w_mult, w_multu, w_div, w_divu, w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic [31:0] w_pc, w_rs, w_rt, w_src1, w_src2, w_alu_res, w_ex_result;
    logic [15:0] w_imm;
    logic [4:0]  w_sa, w_rf_waddr;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel1;
    logic [3:0]  w_sel2, w_ram_wen;
    logic        w_ram_en, w_rf_we, w_sel_rf_res, w_unused_inst;
    logic        w_md_op, w_signed, w_mul_now, w_start, w_dvz, w_stallreq, w_load;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
    logic [32:0] w_trial;
    logic [63:0] w_prod;
    logic        w_hi_we, w_lo_we;
    logic [31:0] w_hi_nxt, w_lo_nxt, w_hi_fwd, w_lo_fwd;

    assign {w_mult, w_multu, w_div, w_divu} = r_id[166:163];
    assign {w_mfhi, w_mflo, w_mthi, w_mtlo} = r_id[162:159];
    assign w_pc          = r_id[158:127];
    assign w_imm         = r_id[110:95];
    assign w_sa          = r_id[105:101];
    assign w_unused_inst = &{1'b0, r_id[126:111]};
    assign w_alu_op      = r_id[94:83];
    assign w_sel1        = r_id[82:80];
    assign w_sel2        = r_id[79:76];
    assign w_ram_en      = r_id[75];
    assign w_ram_wen     = r_id[74:71];
    assign w_rf_we       = r_id[70];
    assign w_rf_waddr    = r_id[69:65];
    assign w_sel_rf_res  = r_id[64];
    assign w_rs          = r_id[63:32];
    assign w_rt          = r_id[31:0];

    assign w_src1 = ({32{w_sel1[0]}} & w_rs)
                  | ({32{w_sel1[1]}} & w_pc)
                  | ({32{w_sel1[2]}} & {27'b0, w_sa});
    assign w_src2 = ({32{w_sel2[0]}} & w_rt)
                  | ({32{w_sel2[1]}} & {{16{w_imm[15]}}, w_imm})
                  | ({32{w_sel2[2]}} & 32'd8)
                  | ({32{w_sel2[3]}} & {16'b0, w_imm});

    always_comb begin
        w_alu_res = 32'b0;
        if      (w_alu_op[11]) w_alu_res = w_src1 + w_src2;
        else if (w_alu_op[10]) w_alu_res = w_src1 - w_src2;
        else if (w_alu_op[9])  w_alu_res = {31'b0, ($signed(w_src1) < $signed(w_src2))};
        else if (w_alu_op[8])  w_alu_res = {31'b0, (w_src1 < w_src2)};
        else if (w_alu_op[7])  w_alu_res = w_src1 & w_src2;
        else if (w_alu_op[6])  w_alu_res = ~(w_src1 | w_src2);
        else if (w_alu_op[5])  w_alu_res = w_src1 | w_src2;
        else if (w_alu_op[4])  w_alu_res = w_src1 ^ w_src2;
        else if (w_alu_op[3])  w_alu_res = w_src2 << w_src1[4:0];
        else if (w_alu_op[2])  w_alu_res = w_src2 >> w_src1[4:0];
        else if (w_alu_op[1])  w_alu_res = $signed(w_src2) >>> w_src1[4:0];
        else if (w_alu_op[0])  w_alu_res = {w_src2[15:0], 16'h0};
    end

`ifdef ITER_MUL_EN
    logic [32:0] w_acc;
    logic [63:0] w_p_fix;
    // Shift-add step: r_rem is the running high half, r_quo shifts out the multiplier.
    assign w_acc     = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvsr} : 33'b0);
    assign w_p_fix   = (w_a_neg ^ w_b_neg) ? -{r_rem, r_quo} : {r_rem, r_quo};
    assign w_md_op   = w_div | w_divu | w_mult | w_multu;
    assign w_signed  = w_div | w_mult;
    assign w_mul_now = 1'b0;
    assign w_prod    = w_p_fix;
`else
    assign w_md_op   = w_div | w_divu;
    assign w_signed  = w_div;
    assign w_mul_now = w_mult | w_multu;
    assign w_prod    = w_mult ? ({{32{w_rs[31]}}, w_rs} * {{32{w_rt[31]}}, w_rt})
                              : ({32'b0, w_rs} * {32'b0, w_rt});
`endif

    assign w_a_neg    = w_signed & w_rs[31];
    assign w_b_neg    = w_signed & w_rt[31];
    assign w_a_mag    = w_a_neg ? -w_rs : w_rs;
    assign w_b_mag    = w_b_neg ? -w_rt : w_rt;
    assign w_dvz      = (w_div | w_divu) && (w_rt == 32'b0);
    assign w_start    = (r_state == ST_IDLE) && w_md_op && !r_done;
    assign w_stallreq = w_start || (r_state == ST_RUN);
    assign w_load     = !bus.stall[2] || !bus.stall[3];
    assign w_trial    = {r_rem, r_quo[31]} - {1'b0, r_dvsr};
    // The instruction is held through RUN, so sign fix-up reads the register directly.
    assign w_q_fix    = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
    assign w_r_fix    = w_a_neg ? -r_rem : r_rem;

    always_comb begin
        w_hi_we  = 1'b0;
        w_lo_we  = 1'b0;
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_state == ST_DONE) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            if (w_mult || w_multu) begin
                {w_hi_nxt, w_lo_nxt} = w_prod;
            end else begin
                w_hi_nxt = w_dvz ? w_rs : w_r_fix;
                w_lo_nxt = w_dvz ? 32'hFFFF_FFFF : w_q_fix;
            end
        end else if (w_mul_now) begin
            w_hi_we  = 1'b1;
            w_lo_we  = 1'b1;
            {w_hi_nxt, w_lo_nxt} = w_prod;
        end else begin
            if (w_mthi) begin w_hi_we = 1'b1; w_hi_nxt = w_rs; end
            if (w_mtlo) begin w_lo_we = 1'b1; w_lo_nxt = w_rs; end
        end
    end

    assign w_hi_fwd    = w_hi_we ? w_hi_nxt : r_hi;
    assign w_lo_fwd    = w_lo_we ? w_lo_nxt : r_lo;
    assign w_ex_result = w_mfhi ? w_hi_fwd : (w_mflo ? w_lo_fwd : w_alu_res);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id   <= '0;
            r_done <= 1'b0;
            r_hi   <= 32'b0;
            r_lo   <= 32'b0;
        end else begin
            if (!bus.stall[2])      r_id <= bus.id_to_ex_bus;
            else if (!bus.stall[3]) r_id <= '0;
            if (w_load)                    r_done <= 1'b0;
            else if (r_state == ST_DONE)   r_done <= 1'b1;
            if (!w_stallreq && w_hi_we) r_hi <= w_hi_nxt;
            if (!w_stallreq && w_lo_we) r_lo <= w_lo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dvsr  <= 32'b0;
            r_quo   <= 32'b0;
            r_rem   <= 32'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_cnt   <= '0;
                    r_dvsr  <= w_b_mag;
                    r_quo   <= w_a_mag;
                    r_rem   <= 32'b0;
                    r_state <= w_dvz ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
`ifdef ITER_MUL_EN
                    if (w_mult || w_multu) begin
                        r_rem <= w_acc[32:1];
                        r_quo <= {w_acc[0], r_quo[31:1]};
                    end else
`endif
                    begin
                        r_rem <= w_trial[32] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
                        r_quo <= {r_quo[30:0], ~w_trial[32]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DIV_CYCLES - 1)) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ex_to_mem_bus   = EX_TO_MEM_WD'({w_pc, w_ram_en, w_ram_wen, w_sel_rf_res,
                                                w_rf_we, w_rf_waddr, w_ex_result});
    assign bus.ex_rf_we        = w_rf_we;
    assign bus.ex_rf_waddr     = w_rf_waddr;
    assign bus.ex_ex_result    = w_ex_result;
    assign bus.data_sram_en    = w_ram_en;
    assign bus.data_sram_wen   = w_ram_wen;
    assign bus.data_sram_addr  = w_alu_res;
    assign bus.data_sram_wdata = w_rt;
    assign bus.stallreq_for_ex = w_stallreq;
endmodule
